// File: rtl/cv32e40p_pkg.sv
// Shared writeback types: result source ids and the address/data request record.
package cv32e40p_pkg;

  localparam int unsigned WB_ADDR_WIDTH = 6;
  localparam int unsigned WB_DATA_WIDTH = 32;
  localparam int unsigned WB_NUM_SRC    = 3;

  // Enumerator order is the grant priority order.
  typedef enum logic [1:0] {
    WB_SRC_LSU = 2'd0,
    WB_SRC_ALU = 2'd1,
    WB_SRC_FPU = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] waddr;
    logic [WB_DATA_WIDTH-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/cv32e40p_rf_wb_arbiter_if.sv
// Result producer handshakes and register file write ports of the writeback arbiter.
interface cv32e40p_rf_wb_arbiter_if
  import cv32e40p_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH
);

  logic                  alu_valid_i, lsu_valid_i, fpu_valid_i;
  logic                  alu_ready_o, lsu_ready_o, fpu_ready_o;
  logic [ADDR_WIDTH-1:0] alu_waddr_i, lsu_waddr_i, fpu_waddr_i;
  logic [DATA_WIDTH-1:0] alu_wdata_i, lsu_wdata_i, fpu_wdata_i;
  logic [ADDR_WIDTH-1:0] waddr_a_o, waddr_b_o;
  logic [DATA_WIDTH-1:0] wdata_a_o, wdata_b_o;
  logic                  we_a_o, we_b_o;
  logic                  fpu_fifo_full_o;

  modport master (
    output alu_valid_i, lsu_valid_i, fpu_valid_i,
    output alu_waddr_i, lsu_waddr_i, fpu_waddr_i,
    output alu_wdata_i, lsu_wdata_i, fpu_wdata_i,
    input  alu_ready_o, lsu_ready_o, fpu_ready_o,
    input  waddr_a_o, waddr_b_o, wdata_a_o, wdata_b_o, we_a_o, we_b_o,
    input  fpu_fifo_full_o
  );

  modport slave (
    input  alu_valid_i, lsu_valid_i, fpu_valid_i,
    input  alu_waddr_i, lsu_waddr_i, fpu_waddr_i,
    input  alu_wdata_i, lsu_wdata_i, fpu_wdata_i,
    output alu_ready_o, lsu_ready_o, fpu_ready_o,
    output waddr_a_o, waddr_b_o, wdata_a_o, wdata_b_o, we_a_o, we_b_o,
    output fpu_fifo_full_o
  );

endinterface

// File: rtl/cv32e40p_wb_fifo.sv
// FPU result buffer: power-of-two circular FIFO with registered count and head read.
module cv32e40p_wb_fifo
  import cv32e40p_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  wb_req_t push_req_i,
  input  logic    pop_i,
  output wb_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  wb_req_t         mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_req_i;
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40p_rf_wb_arbiter.sv
// Writeback arbiter: grants up to two of LSU/ALU/buffered-FPU results per cycle onto
// the two register file write ports, with registered write outputs.
module cv32e40p_rf_wb_arbiter
  import cv32e40p_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int unsigned FPU_FIFO_DEPTH = 2
) (
  input logic                     clk,
  input logic                     rst,
  cv32e40p_rf_wb_arbiter_if.slave bus
);

  wb_req_t               cand_req [WB_NUM_SRC];
  logic [WB_NUM_SRC-1:0] cand_v, gnt;
  wb_src_e               src_a, src_b;
  logic                  gnt_a, gnt_b, seen_b;
  logic                  lsu_x0, alu_x0;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  wb_req_t               fifo_head;

  logic                  we_a_q, we_b_q;
  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_b_q;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_b_q;

  assign lsu_x0 = (bus.lsu_waddr_i == '0);
  assign alu_x0 = (bus.alu_waddr_i == '0);

  // FPU results to x0 are accepted but never buffered.
  assign fifo_push = bus.fpu_valid_i && bus.fpu_ready_o && (bus.fpu_waddr_i != '0);
  assign fifo_pop  = gnt[WB_SRC_FPU];

  cv32e40p_wb_fifo #(
    .Depth (FPU_FIFO_DEPTH)
  ) u_fpu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .push_req_i ('{waddr: bus.fpu_waddr_i, wdata: bus.fpu_wdata_i}),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    cand_req[WB_SRC_LSU] = '{waddr: bus.lsu_waddr_i, wdata: bus.lsu_wdata_i};
    cand_req[WB_SRC_ALU] = '{waddr: bus.alu_waddr_i, wdata: bus.alu_wdata_i};
    cand_req[WB_SRC_FPU] = fifo_head;

    cand_v             = '0;
    cand_v[WB_SRC_LSU] = !rst && bus.lsu_valid_i && !lsu_x0;
    cand_v[WB_SRC_ALU] = !rst && bus.alu_valid_i && !alu_x0;
    cand_v[WB_SRC_FPU] = !rst && !fifo_empty;

    gnt_a  = 1'b0;
    gnt_b  = 1'b0;
    seen_b = 1'b0;
    src_a  = WB_SRC_LSU;
    src_b  = WB_SRC_LSU;
    // Second candidate gets port B unless it collides with port A's address; it then
    // waits so that the lower-priority write lands last.
    for (int unsigned i = 0; i < WB_NUM_SRC; i++) begin
      if (cand_v[i]) begin
        if (!gnt_a) begin
          gnt_a = 1'b1;
          src_a = wb_src_e'(i[1:0]);
        end else if (!seen_b) begin
          seen_b = 1'b1;
          if (cand_req[i].waddr != cand_req[src_a].waddr) begin
            gnt_b = 1'b1;
            src_b = wb_src_e'(i[1:0]);
          end
        end
      end
    end

    gnt = '0;
    if (gnt_a) gnt[src_a] = 1'b1;
    if (gnt_b) gnt[src_b] = 1'b1;
  end

  assign bus.lsu_ready_o = !rst && bus.lsu_valid_i && (lsu_x0 || gnt[WB_SRC_LSU]);
  assign bus.alu_ready_o = !rst && bus.alu_valid_i && (alu_x0 || gnt[WB_SRC_ALU]);
  assign bus.fpu_ready_o = !rst && !fifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      we_a_q    <= 1'b0;
      we_b_q    <= 1'b0;
      waddr_a_q <= '0;
      waddr_b_q <= '0;
      wdata_a_q <= '0;
      wdata_b_q <= '0;
    end else begin
      we_a_q <= gnt_a;
      we_b_q <= gnt_b;
      if (gnt_a) begin
        waddr_a_q <= cand_req[src_a].waddr;
        wdata_a_q <= cand_req[src_a].wdata;
      end
      if (gnt_b) begin
        waddr_b_q <= cand_req[src_b].waddr;
        wdata_b_q <= cand_req[src_b].wdata;
      end
    end
  end

  assign bus.we_a_o          = we_a_q;
  assign bus.we_b_o          = we_b_q;
  assign bus.waddr_a_o       = waddr_a_q;
  assign bus.waddr_b_o       = waddr_b_q;
  assign bus.wdata_a_o       = wdata_a_q;
  assign bus.wdata_b_o       = wdata_b_q;
  assign bus.fpu_fifo_full_o = fifo_full;

endmodule
